note_arbiter: RTL and testbench



---
 rtl/note_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_note_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_arbiter.sv
// Shares one tone generator and the buzzer among N_REQ note requesters; index 0 has top priority and may preempt.
// Grant 1 cycle after a sampled req; done pulses on the last gap cycle, or the cycle after a cancel or preemption.
module note_arbiter #(
    parameter int N_REQ    = 4,
    parameter int CLK_HZ   = 100000000,
    parameter int TICK_DIV = 100000,
    parameter int GAP_MS   = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [3*N_REQ-1:0]  note,
    input  logic [2*N_REQ-1:0]  octave,
    input  logic [12*N_REQ-1:0] dur_ms,
    input  logic                cancel,
    output logic [N_REQ-1:0]    grant,
    output logic [N_REQ-1:0]    done,
    output logic                aborted,
    output logic                busy,
    output logic                buzzer,
    output logic [2:0]          cur_note
);
    typedef enum logic [1:0] {IDLE, PLAY, GAP, FIN} state_t;

    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
    localparam logic [11:0] GAP_LAST  = 12'(GAP_MS - 1);

    function automatic logic [31:0] half_period(input logic [2:0] n, input logic [1:0] o);
        logic [31:0] base;
        case (n)
            3'd1:    base = 32'(CLK_HZ / (2 * 262));
            3'd2:    base = 32'(CLK_HZ / (2 * 294));
            3'd3:    base = 32'(CLK_HZ / (2 * 330));
            3'd4:    base = 32'(CLK_HZ / (2 * 349));
            3'd5:    base = 32'(CLK_HZ / (2 * 392));
            3'd6:    base = 32'(CLK_HZ / (2 * 440));
            3'd7:    base = 32'(CLK_HZ / (2 * 494));
            default: base = 32'd1;
        endcase
        case (o)
            2'd0:    half_period = base << 1;
            2'd2:    half_period = base >> 1;
            default: half_period = base;
        endcase
    endfunction

    state_t             state, state_nxt;
    logic [N_REQ-1:0]   sel_oh;
    logic [2:0]         sel_note;
    logic [1:0]         sel_oct;
    logic [11:0]        sel_dur;
    logic               any_req;
    logic [2:0]         note_q;
    logic [31:0]        hp_q;
    logic [11:0]        dur_q;
    logic [31:0]        cyc_cnt;
    logic [11:0]        tick_cnt;
    logic [31:0]        tone_cnt;
    logic               ab_q;
    logic               done_fire;
    logic               last_tick, last_play, last_gap, kill;

    // Descending scan so the lowest asserted index wins.
    always_comb begin
        any_req  = 1'b0;
        sel_oh   = '0;
        sel_note = '0;
        sel_oct  = '0;
        sel_dur  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                any_req   = 1'b1;
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
                sel_note  = note[3*i +: 3];
                sel_oct   = octave[2*i +: 2];
                sel_dur   = dur_ms[12*i +: 12];
            end
        end
    end

    assign last_tick = (cyc_cnt == TICK_LAST);
    assign last_play = last_tick && (tick_cnt == dur_q - 12'd1);
    assign last_gap  = last_tick && (tick_cnt == GAP_LAST);
    assign kill      = cancel || (req[0] && !grant[0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // A completing gap takes precedence over a late cancel or preemption.
    always_comb begin
        state_nxt = state;
        done_fire = 1'b0;
        case (state)
            IDLE: if (any_req) state_nxt = (sel_dur == 12'd0) ? FIN : PLAY;
            PLAY: begin
                if (kill) begin
                    state_nxt = FIN;
                end else if (last_play) begin
                    if (GAP_MS == 0) begin
                        state_nxt = IDLE;
                        done_fire = 1'b1;
                    end else begin
                        state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                if (last_gap) begin
                    state_nxt = IDLE;
                    done_fire = 1'b1;
                end else if (kill) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                state_nxt = IDLE;
                done_fire = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant    <= '0;
            note_q   <= '0;
            hp_q     <= '0;
            dur_q    <= '0;
            ab_q     <= 1'b0;
            cyc_cnt  <= '0;
            tick_cnt <= '0;
            tone_cnt <= '0;
            buzzer   <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (any_req) begin
                    grant  <= sel_oh;
                    note_q <= sel_note;
                    hp_q   <= half_period(sel_note, sel_oct);
                    dur_q  <= sel_dur;
                end
                ab_q <= 1'b0;
            end else if (state_nxt == IDLE) begin
                grant  <= '0;
                note_q <= '0;
            end else if (state_nxt == FIN) begin
                ab_q <= 1'b1;
            end

            if (state == IDLE || state_nxt != state) begin
                cyc_cnt  <= '0;
                tick_cnt <= '0;
            end else if (last_tick) begin
                cyc_cnt  <= '0;
                tick_cnt <= tick_cnt + 12'd1;
            end else begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end

            if (state != PLAY || state_nxt != PLAY) begin
                tone_cnt <= '0;
                buzzer   <= 1'b0;
            end else if (note_q != 3'd0) begin
                if (tone_cnt == hp_q - 32'd1) begin
                    tone_cnt <= '0;
                    buzzer   <= ~buzzer;
                end else begin
                    tone_cnt <= tone_cnt + 32'd1;
                end
            end
        end
    end

    assign done     = done_fire ? grant : '0;
    assign aborted  = (state == FIN) && ab_q;
    assign busy     = |grant;
    assign cur_note = note_q;

endmodule

// File: tb/tb_note_arbiter.sv
// Randomized and directed checks of note_arbiter against a cycle-index model of tone, timing and arbitration.
`timescale 1ns/1ps
module tb_note_arbiter;
    localparam int N      = 4;
    localparam int CLK_HZ = 1000000;
    localparam int TD     = 1000;
    localparam int GAP    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [11:0] note;
    logic [7:0]  octave;
    logic [47:0] dur_ms;
    logic        cancel;
    logic [3:0]  grant, done;
    logic        aborted, busy, buzzer;
    logic [2:0]  cur_note;

    int checks = 0;
    int errors = 0;
    int waited;
    int obs_buz_bad, obs_first_bad, obs_done_k, obs_done_cnt, obs_grant_bad;
    logic obs_ab, obs_end_busy;
    logic [3:0] obs_end_grant;

    always #5 clk = ~clk;

    note_arbiter #(.N_REQ(N), .CLK_HZ(CLK_HZ), .TICK_DIV(TD), .GAP_MS(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .note(note), .octave(octave), .dur_ms(dur_ms),
        .cancel(cancel), .grant(grant), .done(done), .aborted(aborted), .busy(busy),
        .buzzer(buzzer), .cur_note(cur_note)
    );

    function automatic int half_per(int n, int o);
        int f, h;
        case (n)
            1: f = 262; 2: f = 294; 3: f = 330; 4: f = 349;
            5: f = 392; 6: f = 440; default: f = 494;
        endcase
        h = CLK_HZ / (2 * f);
        if (o == 0) return h * 2;
        if (o == 2) return h / 2;
        return h;
    endfunction

    // Square wave starts low and flips every half period; silent for rests and after the note.
    function automatic logic exp_buzz(int k, int n, int o, int d);
        if (n == 0 || k >= d * TD) return 1'b0;
        return ((k / half_per(n, o)) % 2) == 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(int i, int n, int o, int d);
        note[3*i +: 3]    = 3'(n);
        octave[2*i +: 2]  = 2'(o);
        dur_ms[12*i +: 12] = 12'(d);
    endtask

    task automatic wait_grant(int limit);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (grant == 4'b0 && waited < limit);
    endtask

    // Called on the first grant cycle; walks the whole note up to the following idle cycle.
    task automatic observe(int i, int n, int o, int d);
        int last;
        last = (d + GAP) * TD;
        obs_buz_bad = 0; obs_first_bad = -1; obs_done_k = -1; obs_done_cnt = 0;
        obs_grant_bad = 0; obs_ab = 1'b0;
        for (int k = 0; k <= last; k++) begin
            if (k > 0) tick();
            if (buzzer !== exp_buzz(k, n, o, d)) begin
                obs_buz_bad++;
                if (obs_first_bad < 0) obs_first_bad = k;
            end
            if (done !== 4'b0) begin
                obs_done_cnt++;
                obs_done_k = k;
                obs_ab = obs_ab | aborted;
                if (done !== 4'(1 << i)) obs_grant_bad++;
            end
            if (k < last && grant !== 4'(1 << i)) obs_grant_bad++;
        end
        obs_end_grant = grant;
        obs_end_busy  = busy;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++; if ({grant, done, aborted, busy, buzzer, cur_note} !== 14'b0) begin errors++; $display("FAIL reset_outputs: got %b expected all zero", {grant, done, aborted, busy, buzzer, cur_note}); end
        rst_n = 1'b1;
        repeat (2) tick();
        checks++; if ({grant, busy} !== 5'b0) begin errors++; $display("FAIL idle_after_reset: got %b expected 0", {grant, busy}); end
    endtask

    task automatic test_single();
        set_fields(2, 6, 1, 3);
        req = 4'b0100;
        wait_grant(4);
        checks++; if (grant !== 4'b0100 || waited != 1) begin errors++; $display("FAIL single_grant: got %b after %0d cycles expected 0100 after 1", grant, waited); end
        checks++; if (cur_note !== 3'd6) begin errors++; $display("FAIL single_cur_note: got %0d expected 6", cur_note); end
        req = 4'b0;
        set_fields(2, 1, 0, 1);
        observe(2, 6, 1, 3);
        checks++; if (obs_buz_bad != 0) begin errors++; $display("FAIL single_buzzer: %0d bad cycles, first at %0d, expected 0", obs_buz_bad, obs_first_bad); end
        checks++; if (obs_done_cnt != 1 || obs_done_k != (3 + GAP) * TD - 1) begin errors++; $display("FAIL single_done: %0d pulses last at %0d expected 1 at %0d", obs_done_cnt, obs_done_k, (3 + GAP) * TD - 1); end
        checks++; if (obs_ab !== 1'b0 || obs_grant_bad != 0) begin errors++; $display("FAIL single_grant_hold: aborted=%b bad grant cycles=%0d expected 0/0", obs_ab, obs_grant_bad); end
        checks++; if (obs_end_grant !== 4'b0 || obs_end_busy !== 1'b0) begin errors++; $display("FAIL single_release: grant=%b busy=%b expected 0/0", obs_end_grant, obs_end_busy); end
    endtask

    task automatic test_back_to_back();
        set_fields(1, 2, 1, 1);
        set_fields(3, 5, 2, 1);
        req = 4'b1010;
        wait_grant(4);
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL prio_first: got %b expected 0010", grant); end
        req[1] = 1'b0;
        observe(1, 2, 1, 1);
        checks++; if (obs_buz_bad != 0 || obs_done_k != (1 + GAP) * TD - 1) begin errors++; $display("FAIL prio_note1: bad buzzer=%0d done at %0d expected 0 and %0d", obs_buz_bad, obs_done_k, (1 + GAP) * TD - 1); end
        checks++; if (obs_end_grant !== 4'b0) begin errors++; $display("FAIL prio_idle_gap: got %b expected 0000", obs_end_grant); end
        tick();
        checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL prio_second: got %b expected 1000", grant); end
        req[3] = 1'b0;
        observe(3, 5, 2, 1);
        checks++; if (obs_buz_bad != 0 || obs_done_cnt != 1 || obs_grant_bad != 0) begin errors++; $display("FAIL prio_note3: bad buzzer=%0d done pulses=%0d bad grant=%0d expected 0/1/0", obs_buz_bad, obs_done_cnt, obs_grant_bad); end
    endtask

    task automatic test_preempt();
        int bad;
        bad = 0;
        set_fields(3, 1, 0, 4);
        req = 4'b1000;
        wait_grant(4);
        req = 4'b0;
        for (int k = 1; k <= 3900; k++) begin
            tick();
            if (buzzer !== exp_buzz(k, 1, 0, 4)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL preempt_low_octave: %0d bad buzzer cycles expected 0", bad); end
        set_fields(0, 3, 1, 1);
        req = 4'b0001;
        tick();
        checks++; if (done !== 4'b1000 || aborted !== 1'b1 || buzzer !== 1'b0 || grant !== 4'b1000) begin errors++; $display("FAIL preempt_abort: done=%b aborted=%b buzzer=%b grant=%b expected 1000/1/0/1000", done, aborted, buzzer, grant); end
        tick();
        checks++; if (grant !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL preempt_idle: grant=%b busy=%b expected 0/0", grant, busy); end
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL preempt_grant0: got %b expected 0001", grant); end
        req = 4'b0;
        observe(0, 3, 1, 1);
        checks++; if (obs_buz_bad != 0 || obs_ab !== 1'b0 || obs_done_k != (1 + GAP) * TD - 1) begin errors++; $display("FAIL preempt_note0: bad buzzer=%0d aborted=%b done at %0d", obs_buz_bad, obs_ab, obs_done_k); end
    endtask

    task automatic test_cancel();
        set_fields(1, 3, 2, 1);
        req = 4'b0010;
        wait_grant(4);
        req = 4'b0;
        repeat (TD + 500) tick();
        checks++; if (buzzer !== 1'b0 || grant !== 4'b0010) begin errors++; $display("FAIL cancel_in_gap: buzzer=%b grant=%b expected 0/0010", buzzer, grant); end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++; if (done !== 4'b0010 || aborted !== 1'b1) begin errors++; $display("FAIL cancel_abort: done=%b aborted=%b expected 0010/1", done, aborted); end
        tick();
        checks++; if (grant !== 4'b0 || busy !== 1'b0 || done !== 4'b0) begin errors++; $display("FAIL cancel_idle: grant=%b busy=%b done=%b expected zeros", grant, busy, done); end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++; if ({grant, done, aborted, busy, buzzer, cur_note} !== 14'b0) begin errors++; $display("FAIL cancel_ignored_idle: got %b expected all zero", {grant, done, aborted, busy, buzzer, cur_note}); end
        set_fields(2, 7, 1, 2);
        req = 4'b0100;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        req = 4'b0;
        checks++; if (grant !== 4'b0100 || done !== 4'b0) begin errors++; $display("FAIL cancel_with_grant: grant=%b done=%b expected 0100/0000", grant, done); end
        repeat (10) tick();
        set_fields(0, 1, 1, 1);
        req = 4'b0001;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++; if (done !== 4'b0100 || aborted !== 1'b1) begin errors++; $display("FAIL cancel_and_preempt: done=%b aborted=%b expected 0100/1", done, aborted); end
        tick();
        checks++; if (grant !== 4'b0 || done !== 4'b0) begin errors++; $display("FAIL single_abort: grant=%b done=%b expected 0000/0000", grant, done); end
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL cancel_then_grant0: got %b expected 0001", grant); end
        req = 4'b0;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++; if (done !== 4'b0001 || aborted !== 1'b1) begin errors++; $display("FAIL cancel_owner0: done=%b aborted=%b expected 0001/1", done, aborted); end
        tick();
    endtask

    task automatic test_zero_and_rest();
        set_fields(1, 5, 1, 0);
        req = 4'b0010;
        tick();
        req = 4'b0;
        checks++; if (grant !== 4'b0010 || done !== 4'b0010 || aborted !== 1'b0 || buzzer !== 1'b0) begin errors++; $display("FAIL dur0_done: grant=%b done=%b aborted=%b buzzer=%b expected 0010/0010/0/0", grant, done, aborted, buzzer); end
        tick();
        checks++; if (grant !== 4'b0 || busy !== 1'b0 || done !== 4'b0) begin errors++; $display("FAIL dur0_release: grant=%b busy=%b done=%b expected zeros", grant, busy, done); end
        set_fields(2, 0, 1, 2);
        req = 4'b0100;
        wait_grant(4);
        req = 4'b0;
        observe(2, 0, 1, 2);
        checks++; if (obs_buz_bad != 0 || obs_ab !== 1'b0 || obs_done_k != (2 + GAP) * TD - 1) begin errors++; $display("FAIL rest_note: bad buzzer=%0d aborted=%b done at %0d expected 0/0/%0d", obs_buz_bad, obs_ab, obs_done_k, (2 + GAP) * TD - 1); end
    endtask

    task automatic test_reset_mid_note();
        int stray;
        stray = 0;
        set_fields(2, 4, 1, 2);
        req = 4'b0100;
        wait_grant(4);
        req = 4'b0;
        repeat (1500) tick();
        checks++; if (buzzer !== exp_buzz(1500, 4, 1, 2)) begin errors++; $display("FAIL pre_reset_buzzer: got %b expected %b", buzzer, exp_buzz(1500, 4, 1, 2)); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (grant !== 4'b0 || busy !== 1'b0 || buzzer !== 1'b0 || cur_note !== 3'd0) begin errors++; $display("FAIL async_reset: grant=%b busy=%b buzzer=%b cur_note=%0d expected zeros", grant, busy, buzzer, cur_note); end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done !== 4'b0) stray++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (done !== 4'b0) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL reset_no_done: %0d done cycles expected 0", stray); end
        set_fields(1, 2, 0, 1);
        req = 4'b0010;
        wait_grant(4);
        checks++; if (grant !== 4'b0010 || waited != 1) begin errors++; $display("FAIL post_reset_grant: got %b after %0d expected 0010 after 1", grant, waited); end
        req = 4'b0;
        observe(1, 2, 0, 1);
        checks++; if (obs_buz_bad != 0 || obs_done_cnt != 1) begin errors++; $display("FAIL post_reset_note: bad buzzer=%0d done pulses=%0d expected 0/1", obs_buz_bad, obs_done_cnt); end
    endtask

    task automatic test_random();
        int i, n, o, d, extra;
        for (int t = 0; t < 4; t++) begin
            note   = 12'($urandom);
            octave = 8'($urandom);
            dur_ms = 48'({$urandom, $urandom});
            i = $urandom_range(0, 3);
            n = $urandom_range(0, 7);
            o = $urandom_range(0, 3);
            d = $urandom_range(1, 2);
            extra = $urandom_range(0, 15) & ~((1 << (i + 1)) - 1);
            set_fields(i, n, o, d);
            req = 4'((1 << i) | extra);
            wait_grant(4);
            checks++; if (grant !== 4'(1 << i) || waited != 1 || cur_note !== 3'(n)) begin errors++; $display("FAIL rand_grant[%0d]: grant=%b cur_note=%0d after %0d expected %b/%0d after 1", t, grant, cur_note, waited, 4'(1 << i), n); end
            req = 4'b0;
            note = 12'($urandom);
            octave = 8'($urandom);
            observe(i, n, o, d);
            checks++; if (obs_buz_bad != 0) begin errors++; $display("FAIL rand_buzzer[%0d]: note %0d oct %0d, %0d bad cycles first at %0d", t, n, o, obs_buz_bad, obs_first_bad); end
            checks++; if (obs_done_cnt != 1 || obs_done_k != (d + GAP) * TD - 1 || obs_ab !== 1'b0) begin errors++; $display("FAIL rand_done[%0d]: pulses=%0d at %0d aborted=%b expected 1 at %0d/0", t, obs_done_cnt, obs_done_k, obs_ab, (d + GAP) * TD - 1); end
            checks++; if (obs_grant_bad != 0 || obs_end_busy !== 1'b0) begin errors++; $display("FAIL rand_grant_hold[%0d]: bad grant=%0d busy_end=%b expected 0/0", t, obs_grant_bad, obs_end_busy); end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        req    = 4'b0;
        note   = 12'b0;
        octave = 8'b0;
        dur_ms = 48'b0;
        cancel = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_preempt();
        test_cancel();
        test_zero_and_rest();
        test_reset_mid_note();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
